// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: PC-source selects, fetch sequencer states, reset vector.
package mips_pkg;

  localparam logic [2:0] PCSRC_PLUS4  = 3'd0;
  localparam logic [2:0] PCSRC_BRANCH = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_REG    = 3'd3;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_3000;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_REQ  = 2'd1,
    FS_HOLD = 2'd2,
    FS_DROP = 2'd3
  } fetch_state_t;

  // Only branch/jump/register sources can redirect; anything else is treated as no redirect.
  function automatic logic redirect_ok(input logic vld, input logic [2:0] src);
    return vld && ((src == PCSRC_BRANCH) || (src == PCSRC_JUMP) || (src == PCSRC_REG));
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: imem req/ack handshake, one-word decode-stall buffer, stale-fetch discard on redirect.
// Zero-wait memory gives one instruction per cycle; a decode stall parks the word in ibuf and halts the PC.
module fetch_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [2:0]  redirect_src,
  output logic        pc_en,
  output logic [2:0]  pc_src,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic        err
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TMAX = WW'(TIMEOUT);

  fetch_state_t  state;
  logic [31:0]   ibuf;
  logic [2:0]    pend_src;
  logic [WW-1:0] wcnt;
  logic          err_q;
  logic          eff;
  logic [WW-1:0] wcnt_inc;

  assign eff      = redirect_ok(redirect_valid, redirect_src);
  assign imem_req = (state == FS_REQ) || (state == FS_DROP);
  assign err      = err_q;
  assign wcnt_inc = (wcnt == TMAX) ? wcnt : wcnt + WW'(1);

  always_comb begin
    pc_en       = 1'b0;
    pc_src      = PCSRC_PLUS4;
    instr_valid = 1'b0;
    instr_out   = 32'h0;
    case (state)
      FS_REQ: begin
        if (imem_ack) begin
          if (eff) begin
            pc_en  = 1'b1;
            pc_src = redirect_src;
          end else begin
            instr_valid = 1'b1;
            instr_out   = imem_rdata;
            pc_en       = !stall;
          end
        end
      end
      FS_HOLD: begin
        instr_valid = 1'b1;
        instr_out   = ibuf;
        if (eff) begin
          pc_en  = 1'b1;
          pc_src = redirect_src;
        end else begin
          pc_en = !stall;
        end
      end
      FS_DROP: begin
        // A redirect landing on the completing cycle supersedes the pending one.
        if (imem_ack) begin
          pc_en  = 1'b1;
          pc_src = eff ? redirect_src : pend_src;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FS_BOOT;
      ibuf     <= 32'h0;
      pend_src <= PCSRC_PLUS4;
      wcnt     <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        FS_BOOT: state <= FS_REQ;
        FS_REQ: begin
          if (eff && !imem_ack) begin
            pend_src <= redirect_src;
            state    <= FS_DROP;
          end else if (imem_ack && !eff && stall) begin
            ibuf  <= imem_rdata;
            state <= FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (eff || !stall) state <= FS_REQ;
        end
        FS_DROP: begin
          if (eff) pend_src <= redirect_src;
          if (imem_ack) state <= FS_REQ;
        end
        default: state <= FS_BOOT;
      endcase

      // Every exit from REQ/DROP happens on an ack, so clearing on "no wait" covers both cases.
      if (imem_req && !imem_ack) begin
        wcnt <= wcnt_inc;
        if (wcnt_inc == TMAX) err_q <= 1'b1;
      end else begin
        wcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl against a transaction-level fetch model.
module tb_fetch_ctrl;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [2:0]  redirect_src;
  logic        pc_en;
  logic [2:0]  pc_src;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic        err;

  fetch_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req(imem_req),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_src(redirect_src),
    .pc_en(pc_en),
    .pc_src(pc_src),
    .instr_valid(instr_valid),
    .instr_out(instr_out),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        pen;
    logic [2:0]  psrc;
    logic        iv;
    logic [31:0] iout;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: whether boot cycle has passed, the word decode has not yet taken,
  // whether an outstanding fetch is stale and where the PC should go once it completes.
  bit          booted;
  logic [31:0] held_q[$];
  bit          stale;
  logic [2:0]  stale_src;
  int          waitcnt;
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    booted  = 0;
    held_q.delete();
    stale   = 0;
    stale_src = 3'd0;
    waitcnt = 0;
    m_err   = 0;
    sbq.delete();
  endtask

  // Drive one cycle of inputs, predict that cycle's outputs, then advance to just after the next edge.
  task automatic cycle(input bit a, input logic [31:0] d, input bit s, input bit rv, input logic [2:0] rs);
    exp_t e;
    bit   eff;
    bit   fetching;
    imem_ack = a; imem_rdata = d; stall = s; redirect_valid = rv; redirect_src = rs;
    eff = rv && (rs >= 3'd1) && (rs <= 3'd3);
    e = '{req: 1'b0, pen: 1'b0, psrc: 3'd0, iv: 1'b0, iout: 32'h0, err: m_err};
    fetching = booted && (held_q.size() == 0);
    e.req = fetching;
    if (!booted) begin
      booted = 1;
    end else if (held_q.size() != 0) begin
      e.iv = 1; e.iout = held_q[0];
      if (eff) begin e.pen = 1; e.psrc = rs; held_q.delete(); end
      else if (!s) begin e.pen = 1; held_q.delete(); end
    end else if (stale) begin
      if (eff) stale_src = rs;
      if (a) begin e.pen = 1; e.psrc = stale_src; stale = 0; end
    end else if (eff) begin
      if (a) begin e.pen = 1; e.psrc = rs; end
      else begin stale = 1; stale_src = rs; end
    end else if (a) begin
      e.iv = 1; e.iout = d;
      if (s) held_q.push_back(d);
      else e.pen = 1;
    end
    if (fetching && !a) begin
      if (waitcnt < TO) waitcnt++;
      if (waitcnt >= TO) m_err = 1;
    end else begin
      waitcnt = 0;
    end
    sbq.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_pc_en", {31'h0, pc_en}, 32'h0);
    chk("rst_pc_src", {29'h0, pc_src}, 32'h0);
    chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_instr_out", instr_out, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("imem_req", {31'h0, imem_req}, {31'h0, mon_e.req});
      chk("pc_en", {31'h0, pc_en}, {31'h0, mon_e.pen});
      chk("pc_src", {29'h0, pc_src}, {29'h0, mon_e.psrc});
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, mon_e.iv});
      if (mon_e.iv) chk("instr_out", instr_out, mon_e.iout);
      chk("err", {31'h0, err}, {31'h0, mon_e.err});
    end
  end

  initial begin
    rst_n = 1'b1;
    imem_ack = 0; imem_rdata = 0; stall = 0; redirect_valid = 0; redirect_src = 0;
    model_reset();
    #2;
    do_reset();

    // Boot, then zero-wait fetch with no stall.
    cycle(0, 32'h0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, $urandom, 0, 0, 0);

    // Stall parks the word, release restarts fetching.
    cycle(1, 32'h2408_0005, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, $urandom, 1, 0, 0);
    cycle(0, $urandom, 0, 0, 0);
    cycle(1, $urandom, 0, 0, 0);

    // Redirect with ack held off: stale fetch drained, then jump source applied.
    cycle(0, $urandom, 0, 1, 3'd2);
    cycle(0, $urandom, 0, 0, 0);
    cycle(0, $urandom, 0, 0, 0);
    cycle(1, $urandom, 0, 0, 0);

    // Second redirect in DROP coinciding with ack wins; src 0 is ignored.
    cycle(0, $urandom, 0, 1, 3'd1);
    cycle(0, $urandom, 0, 1, 3'd0);
    cycle(1, $urandom, 0, 1, 3'd3);
    cycle(1, $urandom, 0, 1, 3'd0);
    cycle(1, $urandom, 0, 1, 3'd5);

    // Redirect beats stall in HOLD; the held word is not re-presented.
    cycle(1, 32'hDEAD_0001, 1, 0, 0);
    cycle(0, $urandom, 1, 1, 3'd1);
    cycle(1, 32'hBEEF_0002, 0, 0, 0);

    // Timeout sets err, which survives later acks; reset mid-wait clears it.
    for (int i = 0; i < 6; i++) cycle(0, $urandom, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, $urandom, 0, 0, 0);
    cycle(0, $urandom, 0, 0, 0);
    cycle(0, $urandom, 0, 0, 0);
    chk("err_sticky", {31'h0, err}, 32'h1);
    do_reset();

    // Randomized traffic with periodic resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 600 == 599) do_reset();
      cycle(($urandom % 100) < 55, $urandom, ($urandom % 100) < 30,
            ($urandom % 100) < 20, 3'($urandom % 8));
    end

    @(negedge clk); #1;
    chk("sb_drain", sbq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch sequencer for the single-issue MIPS pipeline. Drives the fetch unit's PC enable and PC-source select, and runs a req/ack handshake with a variable-latency instruction memory. Buffers the fetched word while decode stalls, and discards in-flight fetches made stale by a branch or jump redirect. Sits between the hazard/decode logic and the fetch unit / IF-ID register.

## Interface
Parameters:
- TIMEOUT, 255: cycles waiting for ack before `err` is raised; legal range 2..65535.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request; PC must stay stable while high
- imem_ack  in  1  one-cycle pulse: `imem_rdata` is valid for the current PC
- imem_rdata  in  32  fetched instruction word
- stall  in  1  decode cannot accept an instruction this cycle
- redirect_valid  in  1  decode resolved a taken branch, jump or jr this cycle
- redirect_src  in  3  PC source for the redirect: 1 branch, 2 jump, 3 register
- pc_en  out  1  fetch-unit PC load enable
- pc_src  out  3  fetch-unit PC mux select: 0 PC+4, 1 branch, 2 jump, 3 register
- instr_valid  out  1  `instr_out` holds a valid instruction for IF/ID
- instr_out  out  32  instruction to IF/ID
- err  out  1  sticky fetch-timeout flag

## Operation
- States: BOOT, REQ, HOLD, DROP.
- Registers:
  - `state`
  - 32-bit `ibuf`
  - 3-bit `pend_src`
  - wait counter `wcnt` of width clog2(TIMEOUT+1)
  - `err`
- A redirect is effective when `redirect_valid` = 1 and `redirect_src` is 1..3. A `redirect_src` of 0 or 4..7 is ignored and treated as no redirect.
- BOOT: `imem_req`=0, `pc_en`=0. Moves to REQ unconditionally after one cycle.
- REQ: `imem_req`=1. Priority order:
  - Effective redirect with ack: fetched word dropped, `pc_en`=1, `pc_src`=`redirect_src`, stay in REQ.
  - Effective redirect without ack: `pend_src`←`redirect_src`, `pc_en`=0, go to DROP.
  - Ack and !stall: `instr_valid`=1, `instr_out`=`imem_rdata`, `pc_en`=1, `pc_src`=0, stay in REQ.
  - Ack and stall: `instr_valid`=1, `ibuf`←`imem_rdata`, `pc_en`=0, go to HOLD.
  - No ack: wait; all other outputs 0.
- HOLD: `imem_req`=0, `instr_valid`=1, `instr_out`=`ibuf`.
  - Effective redirect: `pc_en`=1, `pc_src`=`redirect_src`, go to REQ (redirect beats stall).
  - Else !stall: `pc_en`=1, `pc_src`=0, go to REQ.
  - Else stay in HOLD.
- DROP: `imem_req`=1 (the old address is held until the memory completes).
  - On ack: word discarded, `pc_en`=1, `pc_src`=`pend_src`, go to REQ.
  - A new effective redirect in DROP overwrites `pend_src`. If it coincides with ack, the new source is used.
- `instr_valid` is never asserted in DROP or BOOT.
- `pc_src` = 0 whenever `pc_en` = 0.
- Timeout:
  - `wcnt` increments each REQ/DROP cycle without ack, saturating at TIMEOUT.
  - `wcnt` clears on ack or on leaving REQ/DROP.
  - `err` sets when `wcnt` reaches TIMEOUT and stays set until reset. Fetching continues regardless.

## Timing
- Reset values (async, take effect immediately):
  - state BOOT
  - `imem_req` 0, `pc_en` 0, `pc_src` 0, `instr_valid` 0, `instr_out` 0
  - `err` 0, `wcnt` 0, `ibuf` 0, `pend_src` 0
- The first `imem_req` is asserted in the second cycle after `rst_n` deasserts.
- `imem_req` and `err` are decoded from registers only.
- `pc_en`, `pc_src`, `instr_valid` and `instr_out` are combinational from state, `imem_ack`, `stall` and redirect in the same cycle.
- With zero-wait memory (ack every requested cycle) and no stall: one instruction per cycle, and `pc_en`=1 every REQ cycle.
- A stall releases in 1 cycle: `instr_valid` from `ibuf` in the release cycle, new request in the next cycle.
- A redirect during an outstanding fetch costs the remaining memory latency plus one request.
- Reset asserted mid-fetch abandons the transaction. The memory must tolerate `imem_req` dropping without ack.

## Structure
- Shared package `mips_pkg` holds:
  - PC-source constants PCSRC_PLUS4=0, PCSRC_BRANCH=1, PCSRC_JUMP=2, PCSRC_REG=3
  - the fetch state enum
  - the reset vector 32'h0000_3000 used by the fetch unit
- Single module. No sub-module needed; the timeout counter stays inline.

## Test plan
- Reset, then ack every cycle, stall=0 for 5 cycles: `imem_req` rises 2 cycles after `rst_n`. `instr_valid`=1, `pc_en`=1, `pc_src`=0 on each of the 5 cycles.
- Ack with `imem_rdata`=32'h2408_0005 and stall=1 for 3 cycles: state HOLD, `instr_out`=32'h2408_0005 for all 3 cycles, `pc_en`=0. Release gives `pc_en`=1, `pc_src`=0, then `imem_req`=1 next cycle.
- Redirect (`redirect_src`=2) with ack held off 3 cycles: DROP entered, `instr_valid` stays 0. On ack, `pc_en`=1, `pc_src`=2, return to REQ.
- In DROP, a second redirect with `redirect_src`=3 coinciding with ack: `pc_src`=3. Also: `redirect_src`=0 with `redirect_valid`=1 has no effect.
- TIMEOUT=4, no ack: `err` rises after 4 waiting cycles and stays 1 after later acks. Asserting `rst_n`=0 mid-wait clears `err` and all outputs asynchronously.
- HOLD with stall=1 and redirect (`redirect_src`=1): `pc_en`=1, `pc_src`=1, state REQ next cycle, buffered word not re-presented.
